// File: rtl/temp_pkg.sv
// temp_pkg -- shared definitions for the temperature sensor reader.
//   TEMP_W     : width of one sensor word.
//   FAULT_WORD : word read when the data line floats high (sensor absent).
//   state_t    : frame sequencer states.
package temp_pkg;

    localparam int TEMP_W = 16;
    localparam logic [TEMP_W-1:0] FAULT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4,
        WAIT  = 3'd5
    } state_t;

endpackage

// File: rtl/temp_avg4.sv
// temp_avg4 -- running mean of the last four accepted temperature samples.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sample_valid  : one-cycle strobe, sample is a good reading
//   sample        : new reading
//   avg           : mean of the four history slots (18-bit sum >> 2)
// The first accepted sample after reset fills every slot so the mean starts
// at the first reading instead of ramping up from zero.
module temp_avg4
    import temp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample,
    output logic [TEMP_W-1:0] avg
);

    logic [TEMP_W-1:0] hist [4];
    logic              primed;
    logic [TEMP_W+1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
            primed <= 1'b0;
        end else if (sample_valid) begin
            if (!primed) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    hist[i] <= sample;
                end
                primed <= 1'b1;
            end else begin
                hist[0] <= sample;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
            end
        end
    end

    always_comb begin
        sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
        avg = sum[TEMP_W+1:2];
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader -- periodic 16-bit SPI-style read of a temperature sensor.
// Parameters:
//   CLK_DIV       : SCLK half-period in clk cycles (>= 2)
//   SAMPLE_PERIOD : clk cycles between frame starts (>= 34*CLK_DIV+4)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start_en   : level, enables periodic sampling
//   sens_cs_n  : sensor chip select (active low)
//   sens_sclk  : sensor serial clock (idles low)
//   sens_miso  : sensor serial data, MSB first
//   t_act      : current temperature word
//   t_valid    : one-cycle pulse, t_act updated this cycle
//   drop_en    : a trustworthy temperature is present
//   busy       : frame in progress (LEAD..DONE)
// Build option: define TEMP_AVG_EN to report the mean of the last four good
// samples (temp_avg4) instead of the raw sample.
module temp_sensor_reader
    import temp_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_en,
    output logic              sens_cs_n,
    output logic              sens_sclk,
    input  logic              sens_miso,
    output logic [TEMP_W-1:0] t_act,
    output logic              t_valid,
    output logic              drop_en,
    output logic              busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PC_W  = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SAMPLE_PERIOD - 1);

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [PC_W-1:0]   period_cnt;
    logic [3:0]        bit_cnt;
    logic              sclk_r;
    logic [TEMP_W-1:0] shift_reg;
    logic              t_valid_r;
    logic              drop_en_r;

    logic div_end;
    logic period_end;
    logic frame_done;
    logic sample_ok;

    always_comb begin
        div_end    = (div_cnt == DIV_LAST);
        period_end = (period_cnt == PC_LAST);
        // The word is complete once TRAIL ends; results are registered on
        // that edge so they are visible during the single DONE cycle.
        frame_done = (state == TRAIL) && div_end;
        sample_ok  = frame_done && (shift_reg != FAULT_WORD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            period_cnt <= '0;
            bit_cnt    <= '0;
            sclk_r     <= 1'b0;
            shift_reg  <= '0;
            t_valid_r  <= 1'b0;
            drop_en_r  <= 1'b0;
        end else begin
            t_valid_r <= 1'b0;

            // Period counter is referenced to the first LEAD cycle of a frame.
            case (state)
                IDLE:    if (start_en) period_cnt <= '0;
                WAIT:    period_cnt <= period_end ? '0 : period_cnt + 1'b1;
                default: period_cnt <= period_cnt + 1'b1;
            endcase

            if (state == LEAD || state == SHIFT || state == TRAIL) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (start_en) state <= LEAD;
                end
                LEAD: begin
                    if (div_end) state <= SHIFT;
                end
                SHIFT: begin
                    if (div_end) begin
                        if (!sclk_r) begin
                            // Same edge that raises SCLK captures the data bit.
                            sclk_r    <= 1'b1;
                            shift_reg <= {shift_reg[TEMP_W-2:0], sens_miso};
                        end else begin
                            sclk_r  <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd15) state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (div_end) begin
                        state     <= DONE;
                        t_valid_r <= sample_ok;
                        drop_en_r <= sample_ok;
                    end
                end
                DONE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (period_end) state <= start_en ? LEAD : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TEMP_AVG_EN
    temp_avg4 u_avg (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_ok),
        .sample       (shift_reg),
        .avg          (t_act)
    );
`else
    logic [TEMP_W-1:0] t_act_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_act_r <= '0;
        end else if (sample_ok) begin
            t_act_r <= shift_reg;
        end
    end

    assign t_act = t_act_r;
`endif

    always_comb begin
        sens_cs_n = !(state == LEAD || state == SHIFT || state == TRAIL);
        busy      = (state == LEAD) || (state == SHIFT) || (state == TRAIL) || (state == DONE);
        sens_sclk = sclk_r;
        t_valid   = t_valid_r;
        drop_en   = drop_en_r;
    end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader -- scoreboard bench for temp_sensor_reader.
// Expected t_act values are queued by the stimulus process; a monitor on the
// falling clock edge pops and compares whenever t_valid is seen, and also
// measures SCLK edges, chip-select low time and frame spacing.
module tb_temp_sensor_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_en;
    logic        sens_cs_n;
    logic        sens_sclk;
    logic        sens_miso;
    logic [15:0] t_act;
    logic        t_valid;
    logic        drop_en;
    logic        busy;

    always #5 clk = ~clk;

    temp_sensor_reader #(
        .CLK_DIV       (4),
        .SAMPLE_PERIOD (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_en  (start_en),
        .sens_cs_n (sens_cs_n),
        .sens_sclk (sens_sclk),
        .sens_miso (sens_miso),
        .t_act     (t_act),
        .t_valid   (t_valid),
        .drop_en   (drop_en),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Sensor model: bit pointer restarts at CS fall and advances after each
    // SCLK rise, so data is stable through the low half before sampling.
    logic [15:0] sensor_word;
    int          bit_idx = 0;

    assign sens_miso = (bit_idx < 16) ? sensor_word[15 - bit_idx] : 1'b1;

    initial begin
        forever begin
            @(negedge sens_cs_n or posedge sens_sclk);
            if (sens_sclk) bit_idx++;
            else           bit_idx = 0;
        end
    end

    // Monitor / scoreboard
    int   cyc = 0;
    int   sclk_rises_cur = 0, last_sclk_rises = 0;
    int   cs_low_cur = 0, last_cs_low = 0;
    int   fall_prev = 0, fall_last = 0;
    int   n_frames = 0;
    int   valid_cnt = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_cs && !sens_cs_n) begin
                fall_prev      = fall_last;
                fall_last      = cyc;
                n_frames++;
                sclk_rises_cur = 0;
                cs_low_cur     = 0;
            end
            if (!prev_cs && sens_cs_n) begin
                last_cs_low     = cs_low_cur;
                last_sclk_rises = sclk_rises_cur;
            end
            if (!sens_cs_n) cs_low_cur++;
            if (!prev_sclk && sens_sclk) sclk_rises_cur++;
            prev_cs   = sens_cs_n;
            prev_sclk = sens_sclk;
            if (t_valid === 1'b1) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("t_valid_unexpected", 32'(t_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("t_act", 32'(t_act), 32'(e));
                    check("drop_en_on_valid", 32'(drop_en), 32'd1);
                end
            end
        end
    end

    task automatic wait_frame_end();
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) return;
        end
        checks++;
        errors++;
        $display("FAIL frame_timeout: busy_seen %0d, expected frame completion", seen);
    endtask

    task automatic wait_rises(input int n);
        int nf0 = n_frames;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n_frames > nf0 && sclk_rises_cur >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL rise_timeout: rises %0d, expected %0d", sclk_rises_cur, n);
    endtask

    logic [15:0] s6_words [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
`ifdef TEMP_AVG_EN
    logic [15:0] s6_exp [4] = '{16'd100, 16'd125, 16'd175, 16'd250};
    localparam logic [15:0] EXP3 = 16'd1465;   // (0x1234 + 3*0x0190) >> 2
    localparam logic [15:0] EXP4 = 16'd2028;   // (0x0A5C + 0x1234 + 2*0x0190) >> 2
`else
    logic [15:0] s6_exp [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    localparam logic [15:0] EXP3 = 16'h1234;
    localparam logic [15:0] EXP4 = 16'h0A5C;
`endif

    initial begin
        int v, nf;
        rst_n       = 1'b0;
        start_en    = 1'b0;
        sensor_word = 16'h0190;
        #12;
        check("reset_outputs", 32'({sens_cs_n, sens_sclk, t_act, t_valid, drop_en, busy}), 32'h0010_0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: good word 0x0190
        exp_q.push_back(16'h0190);
        start_en = 1'b1;
        wait_frame_end();
        check("sclk_rises", 32'(last_sclk_rises), 32'd16);
        check("cs_low_cycles", 32'(last_cs_low), 32'd136);
        check("drop_en_s1", 32'(drop_en), 32'd1);
        check("valid_count_s1", 32'(valid_cnt), 32'd1);

        // Scenario 2: fault word after a good one
        sensor_word = 16'hFFFF;
        v = valid_cnt;
        wait_frame_end();
        check("t_act_hold_fault", 32'(t_act), 32'h0190);
        check("drop_en_fault", 32'(drop_en), 32'd0);
        check("no_valid_fault", 32'(valid_cnt), 32'(v));
        check("frame_spacing_1", 32'(fall_last - fall_prev), 32'd1000);

        // Scenario 3: continuous sampling spacing
        sensor_word = 16'h1234;
        exp_q.push_back(EXP3);
        wait_frame_end();
        check("frame_spacing_2", 32'(fall_last - fall_prev), 32'd1000);
        check("drop_en_recover", 32'(drop_en), 32'd1);

        // Scenario 4: start_en dropped at the 8th bit
        sensor_word = 16'h0A5C;
        exp_q.push_back(EXP4);
        v = valid_cnt;
        wait_rises(8);
        start_en = 1'b0;
        wait_frame_end();
        check("valid_after_stop", 32'(valid_cnt), 32'(v + 1));
        nf = n_frames;
        repeat (2500) @(negedge clk);
        check("no_frames_after_stop", 32'(n_frames), 32'(nf));
        check("idle_after_stop", 32'({sens_cs_n, busy}), 32'b10);

        // Scenario 5: asynchronous reset at the 5th bit
        sensor_word = 16'h7777;
        start_en    = 1'b1;
        wait_rises(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({sens_cs_n, sens_sclk, t_act, t_valid, drop_en, busy}), 32'h0010_0000);
        sensor_word = s6_words[0];
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 6: four good samples after reset
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(s6_exp[i]);
            wait_frame_end();
            if (i < 3) sensor_word = s6_words[i + 1];
        end
        start_en = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
